// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : MEM pipeline stage. It resolves branches, runs the data-memory
//             req/ready handshake and registers results for write-back.
// Revision  : 1.0
// ============================================================================
module mem_stage #(
  parameter int PC_SIZE = 10,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PC_SIZE-1:0] PC_jump,
  input  logic               zero,
  input  logic [7:0]         ALU_result,
  input  logic [7:0]         write_data,
  input  logic               branch_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               mem_to_reg_in,
  input  logic               reg_write_in,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [7:0]         dmem_addr,
  output logic [7:0]         dmem_wdata,
  input  logic [7:0]         dmem_rdata,
  input  logic               dmem_ready,
  output logic               stall,
  output logic               PC_src,
  output logic [PC_SIZE-1:0] PC_target,
  output logic [7:0]         read_data,
  output logic [7:0]         ALU_result_out,
  output logic               mem_to_reg_out,
  output logic               reg_write_out,
  output logic               mem_error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       mem_op;
  logic       timeout_hit;
  logic       complete;
  logic       abort;

  assign mem_op      = mem_read_in | mem_write_in;
  assign timeout_hit = (wait_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stall is released in the abort cycle so upstream moves past the dropped op.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt       <= 8'h00;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 8'h00;
      dmem_wdata     <= 8'h00;
      PC_src         <= 1'b0;
      PC_target      <= '0;
      read_data      <= 8'h00;
      ALU_result_out <= 8'h00;
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      mem_error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Issue: WB side becomes a bubble until the access finishes.
            dmem_req      <= 1'b1;
            dmem_we       <= mem_write_in;
            dmem_addr     <= ALU_result;
            dmem_wdata    <= write_data;
            wait_cnt      <= 8'h00;
            reg_write_out <= 1'b0;
            PC_src        <= 1'b0;
            if (mem_read_in && mem_write_in) begin
              mem_error <= 1'b1;
            end
          end else begin
            read_data      <= 8'h00;
            ALU_result_out <= ALU_result;
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            PC_src         <= branch_in & zero;
            PC_target      <= PC_jump;
          end
        end
        WAIT: begin
          if (complete) begin
            dmem_req       <= 1'b0;
            read_data      <= dmem_we ? 8'h00 : dmem_rdata;
            ALU_result_out <= ALU_result;
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            PC_src         <= 1'b0;
            PC_target      <= PC_jump;
          end else if (abort) begin
            dmem_req      <= 1'b0;
            mem_error     <= 1'b1;
            reg_write_out <= 1'b0;
            read_data     <= 8'h00;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'h01;
          end
        end
        default: begin
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
